// File: rtl/accel_pkg.sv
// Shared constants, FSM encoding and helpers for the accelerometer averaging filter.
// Latency: none (declarations only).
// Backpressure: none.
package accel_pkg;

    localparam int          ACCEL_W        = 12;
    localparam int          SAMPLE_DIV_DEF = 1024;
    localparam int          LOG2_N_DEF     = 3;
    localparam logic [11:0] TILT_THR_DEF   = 12'd256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Magnitude of a 12-bit two's complement value; -2048 maps to 2048, hence 13 bits.
    function automatic logic [ACCEL_W:0] mag12(input logic [ACCEL_W-1:0] v);
        logic [ACCEL_W:0] ext;
        ext = {v[ACCEL_W-1], v};
        return v[ACCEL_W-1] ? (~ext + 1'b1) : ext;
    endfunction

endpackage

// File: rtl/accel_sample_tick.sv
// Sample-rate divider: counts 0..SAMPLE_DIV-1 while en is high, tick marks the last count.
// Latency: tick is combinational from the registered count; the count clears the cycle after en drops.
// Backpressure: none; free-running while enabled.
module accel_sample_tick
    import accel_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_d;

    // Next count: hold at zero while disabled, wrap after the last count.
    always_comb begin
        div_d = div_q;
        if (!en) begin
            div_d = '0;
        end else if (div_q == LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = en && (div_q == LAST);

endmodule

// File: rtl/accel_avg_filter.sv
// Windowed mean of Y/Z accelerometer samples with optional tilt flags (enabled by ACCEL_AVG_TILT_EN).
// Latency: first avg_valid 2^LOG2_N*SAMPLE_DIV+1 cycles after en is seen, then every 2^LOG2_N*SAMPLE_DIV.
// Backpressure: none; avg_valid is a one-cycle pulse, outputs hold between windows and while disabled.
module accel_avg_filter
    import accel_pkg::*;
#(
    parameter int          SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int          LOG2_N     = LOG2_N_DEF,
    parameter logic [11:0] TILT_THR   = TILT_THR_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic [15:0] Y_n,
    input  logic [15:0] Z_n,
    output logic [11:0] y_avg,
    output logic [11:0] z_avg,
    output logic        avg_valid,
    output logic        tilt_y,
    output logic        tilt_z
);

    // Enough headroom for 2^LOG2_N full-scale samples, so the sum never wraps.
    localparam int ACC_W = ACCEL_W + LOG2_N;

    state_t                    state_q;
    logic signed [ACC_W-1:0]   acc_y_q;
    logic signed [ACC_W-1:0]   acc_z_q;
    logic signed [ACC_W-1:0]   acc_y_d;
    logic signed [ACC_W-1:0]   acc_z_d;
    logic signed [ACC_W-1:0]   y_shr;
    logic signed [ACC_W-1:0]   z_shr;
    logic [LOG2_N-1:0]         cnt_q;
    logic [ACCEL_W-1:0]        y_avg_q;
    logic [ACCEL_W-1:0]        z_avg_q;
    logic                      avg_valid_q;
    logic                      tick;
    logic                      div_en;
    logic                      last_smp;

    // The divider idles at zero until the FSM has left IDLE, which sets the first-window latency.
    assign div_en = en && (state_q != IDLE);

    accel_sample_tick #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_sample_tick (
        .clk   (clk),
        .resetn(resetn),
        .en    (div_en),
        .tick  (tick)
    );

    // Sign-extended sums, floor-mean by arithmetic shift, and end-of-window detect.
    always_comb begin
        acc_y_d  = acc_y_q + {{LOG2_N{Y_n[ACCEL_W-1]}}, Y_n[ACCEL_W-1:0]};
        acc_z_d  = acc_z_q + {{LOG2_N{Z_n[ACCEL_W-1]}}, Z_n[ACCEL_W-1:0]};
        y_shr    = acc_y_q >>> LOG2_N;
        z_shr    = acc_z_q >>> LOG2_N;
        last_smp = &cnt_q;
    end

    // Window FSM with accumulators and registered mean outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            acc_y_q     <= '0;
            acc_z_q     <= '0;
            cnt_q       <= '0;
            y_avg_q     <= '0;
            z_avg_q     <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            avg_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (!en) begin
                        // Partial window is dropped; outputs keep their last values.
                        state_q <= IDLE;
                        acc_y_q <= '0;
                        acc_z_q <= '0;
                        cnt_q   <= '0;
                    end else if (tick) begin
                        acc_y_q <= acc_y_d;
                        acc_z_q <= acc_z_d;
                        cnt_q   <= cnt_q + 1'b1;
                        if (last_smp) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Publishes even if en just fell, then leaves for IDLE.
                    y_avg_q     <= y_shr[ACCEL_W-1:0];
                    z_avg_q     <= z_shr[ACCEL_W-1:0];
                    avg_valid_q <= 1'b1;
                    acc_y_q     <= '0;
                    acc_z_q     <= '0;
                    cnt_q       <= '0;
                    state_q     <= en ? ACCUM : IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign y_avg     = y_avg_q;
    assign z_avg     = z_avg_q;
    assign avg_valid = avg_valid_q;

`ifdef ACCEL_AVG_TILT_EN
    logic tilt_y_q;
    logic tilt_z_q;
    logic unused_bits;

    // Tilt flags refresh together with the means, from the same shifted sums.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tilt_y_q <= 1'b0;
            tilt_z_q <= 1'b0;
        end else if (state_q == DONE) begin
            tilt_y_q <= mag12(y_shr[ACCEL_W-1:0]) > {1'b0, TILT_THR};
            tilt_z_q <= mag12(z_shr[ACCEL_W-1:0]) > {1'b0, TILT_THR};
        end
    end

    assign tilt_y      = tilt_y_q;
    assign tilt_z      = tilt_z_q;
    assign unused_bits = ^{Y_n[15:12], Z_n[15:12],
                           y_shr[ACC_W-1:ACCEL_W], z_shr[ACC_W-1:ACCEL_W]};
`else
    logic unused_bits;

    assign tilt_y      = 1'b0;
    assign tilt_z      = 1'b0;
    assign unused_bits = ^{Y_n[15:12], Z_n[15:12], TILT_THR,
                           y_shr[ACC_W-1:ACCEL_W], z_shr[ACC_W-1:ACCEL_W]};
`endif

endmodule

// File: tb/tb_accel_avg_filter.sv
// Bench for accel_avg_filter: timing-level reference model plus directed vectors.
// Latency: model expectations are compared every cycle on the falling edge.
// Backpressure: n/a.
module tb_accel_avg_filter;

    localparam int          SDIV  = 4;
    localparam int          LOGN  = 3;
    localparam int          WIN   = 1 << LOGN;
    localparam int          PER   = WIN * SDIV;
    localparam int          THR   = 200;
`ifdef ACCEL_AVG_TILT_EN
    localparam int          TILT_ON = 1;
`else
    localparam int          TILT_ON = 0;
`endif

    logic        clk;
    logic        resetn;
    logic        en;
    logic [15:0] Y_n;
    logic [15:0] Z_n;
    logic [11:0] y_avg;
    logic [11:0] z_avg;
    logic        avg_valid;
    logic        tilt_y;
    logic        tilt_z;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    accel_avg_filter #(
        .SAMPLE_DIV(SDIV),
        .LOG2_N    (LOGN),
        .TILT_THR  (12'd200)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .en       (en),
        .Y_n      (Y_n),
        .Z_n      (Z_n),
        .y_avg    (y_avg),
        .z_avg    (z_avg),
        .avg_valid(avg_valid),
        .tilt_y   (tilt_y),
        .tilt_z   (tilt_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Timing from the enable edge: captures every SDIV edges, result one edge after the last capture.
    int edge_n  = 0;
    bit running = 0;
    int start_e = 0;
    int qy[$];
    int qz[$];
    int exp_y   = 0;
    int exp_z   = 0;
    int exp_vld = 0;
    int exp_ty  = 0;
    int exp_tz  = 0;

    function automatic int floor_mean(input int s);
        int q;
        q = s / WIN;
        if ((s % WIN) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sx12(input logic [15:0] v);
        logic signed [11:0] s;
        s = v[11:0];
        return int'(s);
    endfunction

    task automatic model_step();
        int t;
        int sy;
        int sz;
        edge_n++;
        exp_vld = 0;
        if (!resetn) begin
            running = 0;
            qy.delete();
            qz.delete();
            exp_y = 0; exp_z = 0; exp_ty = 0; exp_tz = 0;
        end else if (running) begin
            t = edge_n - start_e;
            if (t > 1 && (t % PER) == 1) begin
                sy = 0; sz = 0;
                foreach (qy[i]) sy += qy[i];
                foreach (qz[i]) sz += qz[i];
                exp_y   = floor_mean(sy);
                exp_z   = floor_mean(sz);
                exp_vld = 1;
                exp_ty  = TILT_ON & int'(iabs(exp_y) > THR);
                exp_tz  = TILT_ON & int'(iabs(exp_z) > THR);
                qy.delete();
                qz.delete();
            end
            if (!en) begin
                running = 0;
                qy.delete();
                qz.delete();
            end else if (t > 0 && (t % SDIV) == 0) begin
                qy.push_back(sx12(Y_n));
                qz.push_back(sx12(Z_n));
            end
        end else if (en) begin
            running = 1;
            start_e = edge_n;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (edge_n > 0) begin
            vec_cnt++;
            if (int'($signed(y_avg)) != exp_y || int'($signed(z_avg)) != exp_z ||
                int'(avg_valid) != exp_vld || int'(tilt_y) != exp_ty || int'(tilt_z) != exp_tz) begin
                miss_cnt++;
                $display("FAIL model_cmp edge %0d: got y=%0d z=%0d vld=%0d ty=%0d tz=%0d, need y=%0d z=%0d vld=%0d ty=%0d tz=%0d",
                         edge_n, $signed(y_avg), $signed(z_avg), avg_valid, tilt_y, tilt_z,
                         exp_y, exp_z, exp_vld, exp_ty, exp_tz);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int act, input int req);
        vec_cnt++;
        if (act != req) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, need %0d", name, act, req);
        end
    endtask

    // Call right after a falling edge; returns the index of the edge that first sees en=1.
    task automatic raise_en(output int ref_e);
        en    = 1'b1;
        ref_e = edge_n + 1;
    endtask

    // Edges from ref_e to the edge that produced the next avg_valid; -1 on timeout.
    task automatic wait_pulse(input int ref_e, input int limit, output int lat);
        lat = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (avg_valid === 1'b1) begin
                lat = edge_n - ref_e;
                break;
            end
        end
    endtask

    int ref_e;
    int lat;
    int pulse_y[$];
    int seq_y[16];

    initial begin
        resetn = 1'b0;
        en     = 1'b0;
        Y_n    = 16'h0000;
        Z_n    = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_y",   int'(y_avg), 0);
        chk("rst_z",   int'(z_avg), 0);
        chk("rst_vld", int'(avg_valid), 0);
        chk("rst_ty",  int'(tilt_y), 0);
        chk("rst_tz",  int'(tilt_z), 0);
        resetn = 1'b1;
        @(negedge clk);

        // Steady +256 / -256 with upper nibbles clear.
        Y_n = 16'h0100;
        Z_n = 16'h0F00;
        raise_en(ref_e);
        wait_pulse(ref_e, 60, lat);
        chk("basic_lat1", lat, 33);
        chk("basic_y",    int'($signed(y_avg)), 256);
        chk("basic_z",    int'($signed(z_avg)), -256);
        chk("basic_ty",   int'(tilt_y), TILT_ON);
        chk("basic_tz",   int'(tilt_z), TILT_ON);
        wait_pulse(ref_e, 60, lat);
        chk("basic_lat2", lat, 65);
        en = 1'b0;
        repeat (3) @(negedge clk);

        // Full-scale extremes; garbage in the ignored upper nibble.
        Y_n = 16'hA800;
        Z_n = 16'h57FF;
        raise_en(ref_e);
        wait_pulse(ref_e, 60, lat);
        chk("ext_lat", lat, 33);
        chk("ext_y",   int'($signed(y_avg)), -2048);
        chk("ext_z",   int'($signed(z_avg)), 2047);
        chk("ext_ty",  int'(tilt_y), TILT_ON);
        en = 1'b0;
        repeat (3) @(negedge clk);

        // Ramp 1..8 then -1..-8, random junk between capture edges.
        for (int i = 0; i < 8; i++) begin
            seq_y[i]     = i + 1;
            seq_y[i + 8] = -(i + 1);
        end
        begin
            int idx;
            int t;
            idx = 0;
            raise_en(ref_e);
            t = -1;
            while (t < 65) begin
                @(negedge clk);
                t = edge_n - ref_e;
                if (avg_valid === 1'b1) pulse_y.push_back(int'($signed(y_avg)));
                if (((t + 1) % SDIV) == 0 && idx < 16) begin
                    Y_n = 16'(seq_y[idx]);
                    Z_n = 16'h0000;
                    idx++;
                end else begin
                    Y_n = 16'($urandom);
                    Z_n = 16'($urandom);
                end
            end
        end
        chk("ramp_npulse", pulse_y.size(), 2);
        if (pulse_y.size() == 2) begin
            chk("ramp_pos", pulse_y[0], 4);
            chk("ramp_neg", pulse_y[1], -5);
        end
        en = 1'b0;
        repeat (3) @(negedge clk);

        // Drop en after 5 captures: nothing published, then a fresh window.
        Y_n = 16'h03E8;
        Z_n = 16'h0000;
        raise_en(ref_e);
        repeat (22) @(negedge clk);
        en = 1'b0;
        wait_pulse(ref_e, 12, lat);
        chk("drop_nopulse", lat, -1);
        chk("drop_hold_y",  int'($signed(y_avg)), -5);
        Y_n = 16'h0064;
        Z_n = 16'h0F9C;
        raise_en(ref_e);
        wait_pulse(ref_e, 60, lat);
        chk("reen_lat", lat, 33);
        chk("reen_y",   int'($signed(y_avg)), 100);
        chk("reen_z",   int'($signed(z_avg)), -100);
        chk("reen_ty",  int'(tilt_y), 0);
        en = 1'b0;
        repeat (3) @(negedge clk);

        // en falls exactly in the publish cycle; the result must still appear.
        Y_n = 16'h012C;
        Z_n = 16'h0ED4;
        raise_en(ref_e);
        repeat (33) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("donefall_vld", int'(avg_valid), 1);
        chk("donefall_y",   int'($signed(y_avg)), 300);
        chk("donefall_z",   int'($signed(z_avg)), -300);
        repeat (4) @(negedge clk);

        // Reset mid-window clears everything and leaves no stale pulse.
        Y_n = 16'h01F4;
        raise_en(ref_e);
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_y",   int'(y_avg), 0);
        chk("midrst_z",   int'(z_avg), 0);
        chk("midrst_vld", int'(avg_valid), 0);
        chk("midrst_ty",  int'(tilt_y), 0);
        resetn = 1'b1;
        ref_e  = edge_n + 1;
        wait_pulse(ref_e, 60, lat);
        chk("postrst_lat", lat, 33);
        chk("postrst_y",   int'($signed(y_avg)), 500);
        en = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/accel_avg_filter.md
ACCEL_AVG_FILTER -- requirements
Module: accel_avg_filter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports are named clk and resetn.
REQ-002 The block SHALL have parameter SAMPLE_DIV, default 1024: clk cycles between sample captures (>=2).
REQ-003 The block SHALL have parameter LOG2_N, default 3: window length is 2^LOG2_N samples (1..6).
REQ-004 The block SHALL have parameter TILT_THR, default 12'd256: unsigned tilt magnitude threshold.
REQ-005 The block SHALL have port clk, input, 1 bit: system clock.
REQ-006 The block SHALL have port resetn, input, 1 bit: synchronous active-low reset.
REQ-007 The block SHALL have port en, input, 1 bit: enables sampling and averaging.
REQ-008 The block SHALL have port Y_n, input, 16 bits: raw Y from the accelerometer reader; bits [11:0] are 12-bit two's complement and bits [15:12] are ignored.
REQ-009 The block SHALL have port Z_n, input, 16 bits: raw Z, with the same format as Y_n.
REQ-010 The block SHALL have port y_avg, output, 12 bits: signed windowed mean of Y.
REQ-011 The block SHALL have port z_avg, output, 12 bits: signed windowed mean of Z.
REQ-012 The block SHALL have port avg_valid, output, 1 bit: single-cycle pulse when y_avg/z_avg update.
REQ-013 The block SHALL have port tilt_y, output, 1 bit: |y_avg| > TILT_THR.
REQ-014 The block SHALL have port tilt_z, output, 1 bit: |z_avg| > TILT_THR.

Function
REQ-015 The FSM SHALL have states IDLE, ACCUM and DONE, with transitions IDLE->ACCUM when en=1, ACCUM->DONE when the 2^LOG2_N-th sample is added, DONE->ACCUM after exactly one cycle if en=1, and any state->IDLE when en=0.
REQ-016 The divider SHALL count 0..SAMPLE_DIV-1 while en=1, wrap to 0, run through DONE unchanged, and hold at 0 in IDLE.
REQ-017 On a cycle in ACCUM with divider==SAMPLE_DIV-1, the block SHALL sign-extend Y_n[11:0] and Z_n[11:0], add them into (12+LOG2_N)-bit accumulators and increment the sample count.
REQ-018 Inputs SHALL be sampled only on capture cycles; changes between captures SHALL have no effect.
REQ-019 In DONE, the block SHALL set y_avg/z_avg to the accumulator arithmetically shifted right by LOG2_N (floor toward negative infinity), pulse avg_valid high for exactly that cycle, and clear the accumulators and count.
REQ-020 Latency SHALL be: first avg_valid exactly 2^LOG2_N*SAMPLE_DIV+1 cycles after the first rising edge with en=1; subsequent pulses SHALL occur every 2^LOG2_N*SAMPLE_DIV cycles.
REQ-021 Accumulators SHALL never overflow: all -2048 inputs give -2048 and all +2047 inputs give +2047.
REQ-022 Deasserting en mid-window SHALL discard the partial window, hold y_avg/z_avg/tilt at their last values, and produce no avg_valid pulse.
REQ-023 If en falls in the DONE cycle, the DONE update and pulse SHALL still complete before the FSM enters IDLE.
REQ-024 The magnitude of -2048 SHALL be treated as 2048 for the tilt compare.

Reset
REQ-025 While resetn=0 at a clk edge, the block SHALL enter IDLE with divider, count and accumulators at 0, y_avg=0, z_avg=0, avg_valid=0, tilt_y=0 and tilt_z=0.
REQ-026 Reset mid-window SHALL discard the window and produce no avg_valid pulse.

Configuration
REQ-027 The macro ACCEL_AVG_TILT_EN SHALL control tilt detection: when defined, tilt_y/tilt_z are registered and updated in DONE per REQ-013/014.
REQ-028 When ACCEL_AVG_TILT_EN is undefined, tilt_y/tilt_z SHALL be tied to 0, no comparator logic SHALL exist, and TILT_THR SHALL be unused.

Structure
REQ-029 Package accel_pkg SHALL hold the FSM state encoding, ACCEL_W=12, and the default SAMPLE_DIV/LOG2_N/TILT_THR constants.
REQ-030 The divider SHALL be sub-module accel_sample_tick (inputs clk, resetn, en; output tick); all other logic SHALL stay in accel_avg_filter.

Verification
REQ-031 With SAMPLE_DIV=4, LOG2_N=3, TILT_THR=200, Y_n=16'h0100, Z_n=16'h0F00 and en raised, the bench SHALL see the first avg_valid at cycle 33 with y_avg=256, z_avg=-256, tilt_y=1, tilt_z=1, and the next pulse at cycle 65.
REQ-032 With Y_n[11:0]=12'h800 constant and Z_n[11:0]=12'h7FF constant, the bench SHALL see y_avg=-2048 and z_avg=2047 with no wrap.
REQ-033 With Y samples 1,2,...,8 and then -1,-2,...,-8, the bench SHALL see y_avg=4, then y_avg=-5 (floor).
REQ-034 With en dropped after 5 captures and raised again, the bench SHALL see no pulse and outputs unchanged, and the next pulse exactly 33 cycles after re-enable, averaging only the new samples.
REQ-035 With resetn pulsed low mid-window, the bench SHALL see all outputs 0 on the next cycle and no stale pulse.
REQ-036 Built without ACCEL_AVG_TILT_EN and run with the REQ-031 stimulus, the bench SHALL see y_avg/z_avg identical to REQ-031 and tilt_y=tilt_z=0 throughout.
